lsu_ctrl: RTL and testbench

- Load/store control stage that sits directly upstream of the byte-addressed data memory (synchronous read, 1-cycle latency, byte-mask write).
- Accepts one load/store request per cycle from the MEM pipeline stage using a valid/ready handshake.
- Drives the memory's port-1 address, write data, byte mask and write enable.
- Sign- or zero-extends read data and returns a response using a valid/ready handshake.
- Memory port 2 is not driven by this block.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_load_ext.sv | 25 ++
 rtl/lsu_ctrl.sv | 137 +++++++++++++
 tb/tb_lsu_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store control stage: funct3 encodings,
// byte-mask constants, FSM state type and a size-to-mask helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] BMASK_NONE = 4'b0000;
    localparam logic [3:0] BMASK_B    = 4'b0001;
    localparam logic [3:0] BMASK_H    = 4'b0011;
    localparam logic [3:0] BMASK_W    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        HOLD
    } lsu_state_e;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] mask;
        mask = BMASK_NONE;
        case (funct3)
            F3_B, F3_BU: mask = BMASK_B;
            F3_H, F3_HU: mask = BMASK_H;
            F3_W:        mask = BMASK_W;
            default:     mask = BMASK_NONE;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extender: picks byte/half/word from the memory
// read data and sign- or zero-extends it to XLEN according to funct3.
module lsu_load_ext
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [31:0]     rdata,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{(XLEN-8){rdata[7]}}, rdata[7:0]};
            F3_BU:   data = XLEN'(rdata[7:0]);
            F3_H:    data = {{(XLEN-16){rdata[15]}}, rdata[15:0]};
            F3_HU:   data = XLEN'(rdata[15:0]);
            F3_W:    data = XLEN'(rdata);
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a byte-addressed, 1-cycle-latency memory.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned halfword/word accesses into faults.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wr,
    input  logic [2:0]        i_req_funct3,
    input  logic [XLEN-1:0]   i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [XLEN-1:0]   o_rsp_data,
    output logic              o_rsp_err
);

    lsu_state_e        state, state_next;
    logic              fire;
    logic              addr_oor, f3_ok, misalign, req_err;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              wr_q, err_q;
    logic [XLEN-1:0]   ext_data, live_data, hold_q;

    assign o_req_ready = (state == IDLE) |
                         ((state == RESP) & i_rsp_ready) |
                         ((state == HOLD) & i_rsp_ready);
    assign fire = i_req_valid & o_req_ready;

    always_comb begin
        addr_oor = |i_req_addr[XLEN-1:ADDR_W];
        f3_ok    = 1'b0;
        misalign = 1'b0;
        if (i_req_wr) begin
            f3_ok = (i_req_funct3 == F3_B) | (i_req_funct3 == F3_H) | (i_req_funct3 == F3_W);
        end else begin
            f3_ok = (i_req_funct3 == F3_B)  | (i_req_funct3 == F3_H) | (i_req_funct3 == F3_W) |
                    (i_req_funct3 == F3_BU) | (i_req_funct3 == F3_HU);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        case (i_req_funct3)
            F3_H, F3_HU: misalign = i_req_addr[0];
            F3_W:        misalign = |i_req_addr[1:0];
            default:     misalign = 1'b0;
        endcase
`endif
        req_err = addr_oor | ~f3_ok | misalign;
    end

    // Address holds the last accepted request so the read data stays stable in HOLD.
    assign o_mem_addr  = fire ? i_req_addr[ADDR_W-1:0] : addr_q;
    assign o_mem_wdata = i_req_wdata[31:0];
    assign o_mem_bmask = (fire & ~req_err) ? size_mask(i_req_funct3) : BMASK_NONE;
    assign o_mem_wren  = fire & i_req_wr & ~req_err & ~i_reset;

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .funct3 (funct3_q),
        .rdata  (i_mem_rdata),
        .data   (ext_data)
    );

    assign live_data = (wr_q | err_q) ? '0 : ext_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (fire) state_next = RESP;
            RESP: begin
                if (!i_rsp_ready) state_next = HOLD;
                else              state_next = fire ? RESP : IDLE;
            end
            HOLD: if (i_rsp_ready) state_next = fire ? RESP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_q   <= '0;
            funct3_q <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= '0;
        end else begin
            if (fire) begin
                addr_q   <= i_req_addr[ADDR_W-1:0];
                funct3_q <= i_req_funct3;
                wr_q     <= i_req_wr;
                err_q    <= req_err;
            end
            if ((state == RESP) && !i_rsp_ready) begin
                hold_q <= live_data;
            end
        end
    end

    always_comb begin
        o_rsp_valid = 1'b0;
        o_rsp_err   = 1'b0;
        o_rsp_data  = '0;
        case (state)
            RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = err_q;
                o_rsp_data  = live_data;
            end
            HOLD: begin
                o_rsp_valid = 1'b1;
                o_rsp_err   = err_q;
                o_rsp_data  = hold_q;
            end
            default: begin
                o_rsp_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small byte-addressed memory model;
// expectations follow LSU_MISALIGN_TRAP_EN when it is defined.
module tb_lsu_ctrl;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren;
    logic [31:0] mem_rdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [31:0] bd_data;
    logic [7:0]  mem [0:255];
    int          check_count = 0;
    int          pass_count = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(16), .XLEN(32)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_wr     (req_wr),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_bmask  (mem_bmask),
        .o_mem_wren   (mem_wren),
        .i_mem_rdata  (mem_rdata),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_data   (rsp_data),
        .o_rsp_err    (rsp_err)
    );

    // Byte-addressed memory: synchronous read-old-data, byte-masked port 1, backdoor port 2.
    always @(posedge clk) begin
        logic [7:0] a;
        a = mem_addr[7:0];
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else begin
            if (mem_wren)
                for (int i = 0; i < 4; i++)
                    if (mem_bmask[i]) mem[a + 8'(i)] <= mem_wdata[8*i +: 8];
            if (bd_we)
                for (int i = 0; i < 4; i++) mem[bd_addr + 8'(i)] <= bd_data[8*i +: 8];
        end
        mem_rdata <= {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rdy);
        req_valid  = valid;
        req_wr     = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        rsp_ready  = rdy;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bdWrite(input logic [7:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        bd_addr = addr;
        bd_data = data;
        bd_we   = 1'b1;
        tick();
        bd_we   = 1'b0;
    endtask

    initial begin
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, F3_W, 32'h10, 32'hAAAA5555, 1'b1);
        checkOutput("wren_in_reset", 32'(mem_wren), 32'h0);
        tick(); tick();
        reset = 1'b0;

        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("rst_valid", 32'(rsp_valid), 32'h0);
        checkOutput("rst_err", 32'(rsp_err), 32'h0);
        checkOutput("rst_data", rsp_data, 32'h0);
        checkOutput("rst_ready", 32'(req_ready), 32'h1);
        tick();

        $display("[TB] store word then load word");
        applyStimulus(1'b1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b1);
        checkOutput("sw_bmask", 32'(mem_bmask), 32'hF);
        checkOutput("sw_wren", 32'(mem_wren), 32'h1);
        checkOutput("sw_addr", 32'(mem_addr), 32'h10);
        checkOutput("sw_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        checkOutput("sw_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("sw_rsp_data", rsp_data, 32'h0);
        checkOutput("lw_wren", 32'(mem_wren), 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("lw_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("lw_data", rsp_data, 32'hDEADBEEF);
        checkOutput("lw_err", 32'(rsp_err), 32'h0);
        tick();

        $display("[TB] byte and halfword extension");
        applyStimulus(1'b1, 1'b1, F3_B, 32'h20, 32'h000000F0, 1'b1);
        checkOutput("sb_bmask", 32'(mem_bmask), 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, F3_B, 32'h20, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, F3_BU, 32'h20, 32'h0, 1'b1);
        checkOutput("lb_data", rsp_data, 32'hFFFFFFF0);
        tick();
        applyStimulus(1'b1, 1'b1, F3_H, 32'h20, 32'h00008001, 1'b1);
        checkOutput("lbu_data", rsp_data, 32'h000000F0);
        checkOutput("sh_bmask", 32'(mem_bmask), 32'h3);
        tick();
        applyStimulus(1'b1, 1'b0, F3_H, 32'h20, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("lh_data", rsp_data, 32'hFFFF8001);
        tick();

        $display("[TB] stalled response held while memory changes");
        applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b0);
        tick();
        bd_addr = 8'h10; bd_data = 32'h11223344; bd_we = 1'b1;
        applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
        checkOutput("resp_ready_low", 32'(req_ready), 32'h0);
        checkOutput("resp_data", rsp_data, 32'hDEADBEEF);
        tick();
        bd_we = 1'b0;
        applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
        checkOutput("hold_ready_low", 32'(req_ready), 32'h0);
        checkOutput("hold_valid", 32'(rsp_valid), 32'h1);
        checkOutput("hold_data", rsp_data, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b0);
        checkOutput("hold_data2", rsp_data, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b1);
        checkOutput("hold_release_ready", 32'(req_ready), 32'h1);
        checkOutput("hold_release_data", rsp_data, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("after_hold_data", rsp_data, 32'h00008001);
        tick();

        $display("[TB] back-to-back loads");
        bdWrite(8'h30, 32'h0BADF00D);
        applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        checkOutput("b2b_ready0", 32'(req_ready), 32'h1);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 1'b1);
        checkOutput("b2b_ready1", 32'(req_ready), 32'h1);
        checkOutput("b2b_data0", rsp_data, 32'h11223344);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h30, 32'h0, 1'b1);
        checkOutput("b2b_ready2", 32'(req_ready), 32'h1);
        checkOutput("b2b_data1", rsp_data, 32'h00008001);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        checkOutput("b2b_ready3", 32'(req_ready), 32'h1);
        checkOutput("b2b_data2", rsp_data, 32'h0BADF00D);
        tick();
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("b2b_valid3", 32'(rsp_valid), 32'h1);
        checkOutput("b2b_data3", rsp_data, 32'h11223344);
        tick();

        $display("[TB] access faults");
        applyStimulus(1'b1, 1'b1, F3_W, 32'h0001_0000, 32'h12345678, 1'b1);
        checkOutput("oor_wren", 32'(mem_wren), 32'h0);
        checkOutput("oor_bmask", 32'(mem_bmask), 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 3'd3, 32'h10, 32'h0, 1'b1);
        checkOutput("oor_err", 32'(rsp_err), 32'h1);
        checkOutput("oor_valid", 32'(rsp_valid), 32'h1);
        checkOutput("oor_data", rsp_data, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 3'd4, 32'h10, 32'hFFFFFFFF, 1'b1);
        checkOutput("badst_wren", 32'(mem_wren), 32'h0);
        checkOutput("badst_bmask", 32'(mem_bmask), 32'h0);
        checkOutput("f3_3_err", 32'(rsp_err), 32'h1);
        checkOutput("f3_3_data", rsp_data, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        checkOutput("badst_err", 32'(rsp_err), 32'h1);
        tick();
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("after_err_data", rsp_data, 32'h11223344);
        checkOutput("after_err_err", 32'(rsp_err), 32'h0);
        tick();

        $display("[TB] misaligned word load");
        bdWrite(8'h14, 32'h77665544);
        applyStimulus(1'b1, 1'b0, F3_W, 32'h13, 32'h0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        checkOutput("mis_err", 32'(rsp_err), 32'h1);
        checkOutput("mis_data", rsp_data, 32'h0);
`else
        checkOutput("mis_err", 32'(rsp_err), 32'h0);
        checkOutput("mis_data", rsp_data, 32'h66554411);
`endif
        tick();

        $display("[TB] reset during response");
        applyStimulus(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 1'b1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, F3_W, 32'h10, 32'hFFFFFFFF, 1'b1);
        checkOutput("pre_rst_valid", 32'(rsp_valid), 32'h1);
        checkOutput("rst_mid_wren", 32'(mem_wren), 32'h0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 1'b1);
        checkOutput("post_rst_valid", 32'(rsp_valid), 32'h0);
        checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
        checkOutput("post_rst_data", rsp_data, 32'h0);
        tick();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
